// File: rtl/color_pkg.sv
// Shared types and constants for the colour transmit path: FSM states,
// colour field positions and system defaults.
package color_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_RED  = 3'd2,
    ST_GRN  = 3'd3,
    ST_BLU  = 3'd4,
    ST_CHK  = 3'd5
  } color_state_e;

  localparam int R_MSB = 23;
  localparam int G_MSB = 15;
  localparam int B_MSB = 7;

  localparam logic [23:0] DEFAULT_COLOR  = 24'hFFFFFF;
  localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/color_tx_serializer.sv
// Serialises a 24-bit RGB word into [header] R G B [xor checksum] bytes over
// a valid/ready byte stream, with a one-deep request queue and optional auto-send.
module color_tx_serializer
  import color_pkg::*;
#(
  parameter bit          SEND_HEADER   = 1'b1,
  parameter logic [7:0]  HEADER_BYTE   = DEFAULT_HEADER,
  parameter bit          SEND_CHECKSUM = 1'b1,
  parameter bit          AUTO_SEND     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] color_in,
  input  logic        send,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done,
  output logic        pending,
  output logic [2:0]  state_dbg
);

  // Handshake: a byte moves on a rising clk edge where tx_valid && tx_ready;
  // while tx_valid is high and tx_ready low, tx_data/tx_valid hold unchanged,
  // and tx_valid stays high for the whole frame.

  color_state_e state, state_d;
  logic [23:0]  snapshot, snapshot_d;
  logic [23:0]  last_sent, last_sent_d;
  logic [7:0]   chk, chk_d;
  logic [7:0]   tx_data_d;
  logic         tx_valid_d, busy_d, done_d, pending_d;

  logic         start;
  logic         xfer;
  logic         load;
  logic [7:0]   load_byte;
  logic         finish;

  assign start = send || pending || (AUTO_SEND && (color_in != last_sent));
  assign xfer  = tx_valid && tx_ready;
  assign state_dbg = 3'(state);

  always_comb begin
    state_d     = state;
    snapshot_d  = snapshot;
    last_sent_d = last_sent;
    chk_d       = chk;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
    busy_d      = busy;
    done_d      = 1'b0;
    pending_d   = pending;
    load        = 1'b0;
    load_byte   = 8'h00;
    finish      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          snapshot_d  = color_in;
          last_sent_d = color_in;
          pending_d   = 1'b0;
          busy_d      = 1'b1;
          tx_valid_d  = 1'b1;
          if (SEND_HEADER) begin
            state_d   = ST_HDR;
            tx_data_d = HEADER_BYTE;
            chk_d     = HEADER_BYTE;
          end else begin
            state_d   = ST_RED;
            tx_data_d = color_in[R_MSB -: 8];
            chk_d     = color_in[R_MSB -: 8];
          end
        end
      end
      default: begin
        if (send) pending_d = 1'b1;
        if (xfer) begin
          case (state)
            ST_HDR: begin state_d = ST_RED; load = 1'b1; load_byte = snapshot[R_MSB -: 8]; end
            ST_RED: begin state_d = ST_GRN; load = 1'b1; load_byte = snapshot[G_MSB -: 8]; end
            ST_GRN: begin state_d = ST_BLU; load = 1'b1; load_byte = snapshot[B_MSB -: 8]; end
            ST_BLU: begin
              if (SEND_CHECKSUM) begin
                // chk already folds in every byte of this frame, including B
                state_d   = ST_CHK;
                tx_data_d = chk;
              end else begin
                finish = 1'b1;
              end
            end
            default: finish = 1'b1;
          endcase
        end
      end
    endcase

    if (load) begin
      tx_data_d = load_byte;
      chk_d     = chk ^ load_byte;
    end
    if (finish) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      snapshot  <= 24'h000000;
      last_sent <= DEFAULT_COLOR;
      chk       <= 8'h00;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state     <= state_d;
      snapshot  <= snapshot_d;
      last_sent <= last_sent_d;
      chk       <= chk_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      pending   <= pending_d;
    end
  end

endmodule

// File: tb/tb_color_tx_serializer.sv
// Directed bench for color_tx_serializer: a default-parameter instance (a) and
// an auto-send, header-less, checksum-less instance (b).
module tb_color_tx_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [23:0] color_a = 24'h000000;
  logic        send_a = 1'b0;
  logic        ready_a = 1'b1;
  logic [7:0]  data_a;
  logic        valid_a, busy_a, done_a, pend_a;
  logic [2:0]  st_a;

  logic [23:0] color_b = 24'hFFFFFF;
  logic        send_b = 1'b0;
  logic        ready_b = 1'b1;
  logic [7:0]  data_b;
  logic        valid_b, busy_b, done_b, pend_b;
  logic [2:0]  st_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  color_tx_serializer dut_a (
    .clk(clk), .reset(reset), .color_in(color_a), .send(send_a), .tx_ready(ready_a),
    .tx_data(data_a), .tx_valid(valid_a), .busy(busy_a), .done(done_a),
    .pending(pend_a), .state_dbg(st_a)
  );

  color_tx_serializer #(
    .SEND_HEADER(1'b0), .HEADER_BYTE(8'hA5), .SEND_CHECKSUM(1'b0), .AUTO_SEND(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .color_in(color_b), .send(send_b), .tx_ready(ready_b),
    .tx_data(data_b), .tx_valid(valid_b), .busy(busy_b), .done(done_b),
    .pending(pend_b), .state_dbg(st_b)
  );

  // Advance past the next active edge; outputs are sampled and inputs driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    total_cnt++;
    if ({valid_a, data_a, busy_a, done_a, pend_a, st_a} !== 15'h0) begin
      $display("FAIL reset_state_a: got v=%b d=%h b=%b dn=%b p=%b st=%0d want all 0",
               valid_a, data_a, busy_a, done_a, pend_a, st_a);
    end else pass_cnt++;
    total_cnt++;
    if ({valid_b, data_b, busy_b, done_b, pend_b} !== 12'h0) begin
      $display("FAIL reset_state_b: got v=%b d=%h b=%b dn=%b p=%b want all 0",
               valid_b, data_b, busy_b, done_b, pend_b);
    end else pass_cnt++;
    reset = 1'b0;
    step(); step();
    total_cnt++;
    if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
      $display("FAIL reset_idle: got valid_a=%b valid_b=%b want 0 0", valid_a, valid_b);
    end else pass_cnt++;
  endtask

  task automatic test_basic_frame();
    logic [7:0] exp_bytes [5];
    exp_bytes = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'hD5};
    color_a = 24'h123456; ready_a = 1'b1; send_a = 1'b1;
    step();
    send_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (valid_a !== 1'b1 || data_a !== exp_bytes[i] || busy_a !== 1'b1 || done_a !== 1'b0) begin
        $display("FAIL basic_byte%0d: got v=%b d=%h busy=%b done=%b want v=1 d=%h busy=1 done=0",
                 i, valid_a, data_a, busy_a, done_a, exp_bytes[i]);
      end else pass_cnt++;
      step();
    end
    total_cnt++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || valid_a !== 1'b0) begin
      $display("FAIL basic_done: got done=%b busy=%b v=%b want 1 0 0", done_a, busy_a, valid_a);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (done_a !== 1'b0 || valid_a !== 1'b0 || pend_a !== 1'b0) begin
      $display("FAIL basic_after: got done=%b v=%b p=%b want 0 0 0", done_a, valid_a, pend_a);
    end else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_bytes [5];
    exp_bytes = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'hD5};
    color_a = 24'h123456; ready_a = 1'b1; send_a = 1'b1;
    step();
    send_a = 1'b0;
    step();
    step();
    ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (valid_a !== 1'b1 || data_a !== 8'h34) begin
        $display("FAIL stall_hold%0d: got v=%b d=%h want v=1 d=34", i, valid_a, data_a);
      end else pass_cnt++;
    end
    ready_a = 1'b1;
    for (int i = 3; i < 5; i++) begin
      step();
      total_cnt++;
      if (valid_a !== 1'b1 || data_a !== exp_bytes[i]) begin
        $display("FAIL stall_resume%0d: got v=%b d=%h want v=1 d=%h", i, valid_a, data_a, exp_bytes[i]);
      end else pass_cnt++;
    end
    step();
    total_cnt++;
    if (done_a !== 1'b1 || valid_a !== 1'b0) begin
      $display("FAIL stall_done: got done=%b v=%b want 1 0", done_a, valid_a);
    end else pass_cnt++;
    step();
  endtask

  task automatic test_queue_merge();
    logic [7:0] exp_q [$];
    logic [7:0] exp;
    exp_q = '{8'h12, 8'h34, 8'h56, 8'hD5};
    color_a = 24'h123456; ready_a = 1'b1; send_a = 1'b1;
    step();
    send_a = 1'b1; color_a = 24'h00FF00;
    step();
    send_a = 1'b0;
    total_cnt++;
    if (pend_a !== 1'b1) begin
      $display("FAIL queue_pending: got %b want 1", pend_a);
    end else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      total_cnt++;
      if (valid_a !== 1'b1 || data_a !== exp) begin
        $display("FAIL queue_first%0d: got v=%b d=%h want v=1 d=%h", i, valid_a, data_a, exp);
      end else pass_cnt++;
      send_a = (i == 1);
      step();
      send_a = 1'b0;
    end
    total_cnt++;
    if (done_a !== 1'b1 || pend_a !== 1'b1 || valid_a !== 1'b0) begin
      $display("FAIL queue_done: got done=%b p=%b v=%b want 1 1 0", done_a, pend_a, valid_a);
    end else pass_cnt++;
    step();
    exp_q = '{8'hA5, 8'h00, 8'hFF, 8'h00, 8'h5A};
    for (int i = 0; i < 5; i++) begin
      exp = exp_q.pop_front();
      total_cnt++;
      if (valid_a !== 1'b1 || data_a !== exp || pend_a !== 1'b0) begin
        $display("FAIL queue_second%0d: got v=%b d=%h p=%b want v=1 d=%h p=0",
                 i, valid_a, data_a, pend_a, exp);
      end else pass_cnt++;
      step();
    end
    total_cnt++;
    if (done_a !== 1'b1) begin
      $display("FAIL queue_second_done: got %b want 1", done_a);
    end else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
        $display("FAIL queue_no_third%0d: got v=%b busy=%b want 0 0", i, valid_a, busy_a);
      end else pass_cnt++;
    end
  endtask

  task automatic test_reset_midframe();
    color_a = 24'h123456; ready_a = 1'b1; send_a = 1'b1;
    step();
    send_a = 1'b0;
    step();
    ready_a = 1'b0;
    send_a = 1'b1;
    step();
    send_a = 1'b0;
    total_cnt++;
    if (valid_a !== 1'b1 || data_a !== 8'h12 || pend_a !== 1'b1) begin
      $display("FAIL abort_pre: got v=%b d=%h p=%b want 1 12 1", valid_a, data_a, pend_a);
    end else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || pend_a !== 1'b0 || data_a !== 8'h00) begin
      $display("FAIL abort_async: got v=%b busy=%b p=%b d=%h want 0 0 0 00",
               valid_a, busy_a, pend_a, data_a);
    end else pass_cnt++;
    step();
    reset = 1'b0;
    ready_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
        $display("FAIL abort_idle%0d: got v=%b busy=%b done=%b want 0 0 0", i, valid_a, busy_a, done_a);
      end else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bytes [5];
    exp_bytes = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'hD5};
    color_a = 24'h123456; ready_a = 1'b1; send_a = 1'b1;
    step();
    send_a = 1'b0;
    step(); step(); step(); step();
    total_cnt++;
    if (valid_a !== 1'b1 || data_a !== 8'hD5) begin
      $display("FAIL b2b_chk: got v=%b d=%h want 1 d5", valid_a, data_a);
    end else pass_cnt++;
    send_a = 1'b1;
    step();
    send_a = 1'b0;
    total_cnt++;
    if (done_a !== 1'b1 || pend_a !== 1'b1 || valid_a !== 1'b0) begin
      $display("FAIL b2b_done_pend: got done=%b p=%b v=%b want 1 1 0", done_a, pend_a, valid_a);
    end else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (valid_a !== 1'b1 || data_a !== exp_bytes[i]) begin
        $display("FAIL b2b_next%0d: got v=%b d=%h want 1 %h", i, valid_a, data_a, exp_bytes[i]);
      end else pass_cnt++;
    end
    step();
    total_cnt++;
    if (done_a !== 1'b1 || pend_a !== 1'b0) begin
      $display("FAIL b2b_end: got done=%b p=%b want 1 0", done_a, pend_a);
    end else pass_cnt++;
    step();
  endtask

  task automatic test_auto_send();
    logic [7:0] exp_bytes [3];
    exp_bytes = '{8'hFF, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (valid_b !== 1'b0 || busy_b !== 1'b0) begin
        $display("FAIL auto_quiet%0d: got v=%b busy=%b want 0 0", i, valid_b, busy_b);
      end else pass_cnt++;
    end
    color_b = 24'hFF0000;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (valid_b !== 1'b1 || data_b !== exp_bytes[i]) begin
        $display("FAIL auto_byte%0d: got v=%b d=%h want 1 %h", i, valid_b, data_b, exp_bytes[i]);
      end else pass_cnt++;
    end
    step();
    total_cnt++;
    if (done_b !== 1'b1 || valid_b !== 1'b0) begin
      $display("FAIL auto_done: got done=%b v=%b want 1 0", done_b, valid_b);
    end else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (valid_b !== 1'b0 || done_b !== 1'b0) begin
        $display("FAIL auto_stable%0d: got v=%b done=%b want 0 0", i, valid_b, done_b);
      end else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_queue_merge();
    test_reset_midframe();
    test_back_to_back();
    test_auto_send();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/color_tx_serializer.md
Name: color_tx_serializer

Overview:
Transmit-side counterpart to the colour-configuration path: it takes a 24-bit RGB colour word and emits it as a byte stream toward the UART/link transmitter. Each frame is an optional header byte, then R, G, B, then an optional XOR checksum byte. Downstream flow control is a valid/ready handshake. A frame starts on an explicit `send` pulse or, optionally, automatically whenever the input colour changes.

Parameters:
- SEND_HEADER, 1: 1 = emit HEADER_BYTE before R.
- HEADER_BYTE, 8'hA5: frame sync byte.
- SEND_CHECKSUM, 1: 1 = emit checksum byte after B.
- AUTO_SEND, 0: 1 = start a frame when color_in differs from the last colour sent.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- color_in, input, 24: colour word {R[23:16], G[15:8], B[7:0]}.
- send, input, 1: request to transmit color_in (single-cycle pulse expected).
- tx_ready, input, 1: downstream can accept a byte.
- tx_data, output, 8: current byte.
- tx_valid, output, 1: tx_data is valid.
- busy, output, 1: frame in progress.
- done, output, 1: one-cycle pulse after the last byte of a frame is accepted.
- pending, output, 1: a request is queued behind the current frame.

Behaviour:
- Reset values (asynchronous): tx_valid=0, tx_data=8'h00, busy=0, done=0, pending=0, state=IDLE.
  - Internal last_sent=24'hFFFFFF (white, the system default colour); snapshot=0.
- All outputs are registered.
- FSM states: IDLE, HDR, RED, GRN, BLU, CHK.
- Start condition (IDLE only): send OR pending OR (AUTO_SEND AND color_in != last_sent).
- On the start edge:
  - snapshot<=color_in and last_sent<=color_in.
  - pending<=0.
  - Next state is HDR if SEND_HEADER, else RED.
  - tx_valid=1 with the first byte in the very next cycle, so send-to-first-valid latency is 1 cycle.
- Byte sequence: HDR→HEADER_BYTE; RED→snapshot[23:16]; GRN→snapshot[15:8]; BLU→snapshot[7:0]; CHK→XOR of every byte sent in this frame (header included when sent).
- Handshake:
  - A byte transfers on a clock edge where tx_valid && tx_ready.
  - While tx_valid && !tx_ready, tx_data and tx_valid are held unchanged.
  - tx_valid never drops mid-frame except on reset.
  - Back-to-back bytes are allowed: ready held high gives one byte per cycle.
- Frame end: transfer of the last byte (CHK, or BLU if !SEND_CHECKSUM) → IDLE, tx_valid=0, busy=0, done=1 for exactly one cycle.
- busy=1 from the cycle after start through the cycle of the last transfer.
- Queueing:
  - send while busy sets pending=1. The queue is one deep; extra sends while pending are merged.
  - A send in the same cycle as the last-byte transfer also sets pending.
  - A pending frame starts in the done cycle (IDLE), with first tx_valid the cycle after. It uses color_in as sampled at its start, not at request time.
- color_in changes mid-frame have no effect on that frame because it transmits from the snapshot.
- AUTO_SEND change detection runs only in IDLE. A change during a frame is caught in IDLE afterwards if color_in still differs from last_sent.
- Simultaneous send and auto change in IDLE produce a single frame.
- Reset mid-frame aborts immediately: tx_valid drops asynchronously and the queue and snapshot are cleared.

Decomposition:
- Shared package color_pkg:
  - FSM state enum.
  - Colour field slice constants (R_MSB=23, G_MSB=15, B_MSB=7).
  - Default colour constant 24'hFFFFFF.
  - Default header constant 8'hA5.
- No sub-module; a single flat module with the FSM, snapshot register, checksum accumulator and pending flag.

Test Plan:
1. Defaults, color_in=24'h123456, send pulse, tx_ready=1 → one byte per cycle A5,12,34,56,D5, starting 1 cycle after send; done pulses once; busy low afterwards.
2. tx_ready held 0 for 3 cycles during the GRN byte → tx_data=8'h34 and tx_valid=1 stay stable throughout; sequence resumes unchanged once ready returns.
3. send pulsed twice during a frame and color_in changed to 24'h00FF00 mid-frame → first frame carries the old colour; pending=1; exactly one extra frame A5,00,FF,00,5A follows.
4. AUTO_SEND=1, SEND_HEADER=0, SEND_CHECKSUM=0:
   - After reset with color_in=24'hFFFFFF → no frame.
   - Change color_in to 24'hFF0000 → frame FF,00,00.
   - Hold color_in stable → no further frames.
5. reset asserted while the RED byte is held with tx_ready=0 → tx_valid=0 immediately, busy=0, pending=0; after release, idle with no spurious frame.
6. send coincident with the final CHK transfer → done=1 and pending=1 in the same cycle, and the next frame's first byte is valid the following cycle.
